// File: rtl/tt_uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; bytes arrive on a valid/ready
// handshake from the core and leave LSB first on a single registered tx line.
module tt_uart_tx_fifo #(
    parameter  int CLK_DIV    = 434,
    parameter  int FIFO_DEPTH = 4,
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          tx,
    output logic          busy,
    output logic [CW-1:0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_baud_done;

    assign w_full      = (r_count == FULL_COUNT);
    assign w_push      = in_valid && !w_full;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_baud_done = (r_baud == '0);

    assign in_ready   = !w_full;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_count = r_count;

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // tx and busy are registered one step behind the state, so busy drops
    // exactly when the stop bit has finished on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE) || (r_count != '0) || w_push;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_baud  <= BAUD_RELOAD;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_baud_done) begin
                        r_baud    <= BAUD_RELOAD;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_baud_done) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_baud    <= BAUD_RELOAD;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_baud_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tt_uart_tx_fifo.md
Name: tt_uart_tx_fifo

Overview:
- Output-side serializer that sits directly downstream of the user project core and consumes the 8-bit result bytes the core produces.
- Bytes enter a small FIFO through a valid/ready handshake.
- Bytes leave as 8N1 UART frames on one uo_out pin, so a host can log results without a logic analyser.
- Single clock domain, same clock as the core.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit; legal range ≥ 2; 434 gives 115200 baud at 50 MHz.
- FIFO_DEPTH, 4, number of byte entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  byte to transmit.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a byte; equals !full.
- tx  output  1  UART line; idles high.
- busy  output  1  high while a frame is on the line, or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  current number of FIFO entries.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, busy=0, fifo_count=0, in_ready=1.
  - FSM=IDLE; baud counter and bit index cleared.
  - FIFO pointers cleared.
  - Reset mid-frame aborts the frame; the line returns high the same instant, with no partial stop bit.
- Push:
  - Occurs on a rising edge with in_valid && in_ready.
  - When full, in_ready=0 even if a pop happens the same cycle; no same-cycle push/pop when full.
  - When not full, a push and a pop on the same edge leave fifo_count unchanged.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLK_DIV cycles. Frame length is 10*CLK_DIV cycles.
- FSM states (tx is registered):
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, load baud counter=CLK_DIV-1, go to START.
  - START: tx=0. When the counter reaches 0, reload it, bit index=0, go to DATA.
  - DATA: tx=shift[0]. When the counter reaches 0: shift right, reload, increment index. After index 7, go to STOP.
  - STOP: tx=1. When the counter reaches 0, go to IDLE.
- Latency and gaps:
  - A byte accepted at edge N into an empty idle block drives tx low after edge N+2 (pop at N+1, start bit registered at N+2).
  - Back-to-back: the IDLE→START transition costs one cycle, so consecutive frames are separated by exactly 1 idle-high cycle.
- busy = (FSM != IDLE) || (fifo_count != 0). It deasserts in the cycle after the final stop-bit cycle, provided the FIFO is empty.
- Pointers wrap modulo FIFO_DEPTH. fifo_count saturates naturally because pushes are refused when full. No overflow or underflow is possible.
- in_data is sampled only on accepted pushes; its value at other times is don't-care.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4):
- Reset check: rst high, then released → tx=1, busy=0, in_ready=1, fifo_count=0. Asserting rst mid-frame (during DATA bit 3) → tx=1 immediately; fifo_count=0 after reset.
- Single byte: push 0xA5 at edge N → tx low from edge N+2 for 4 cycles; data bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop high 4 cycles; busy falls at frame end+1.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles → two 40-cycle frames separated by exactly 1 high cycle; fifo_count sequence 1,1,0 (second push coincides with first pop).
- Full FIFO: hold in_valid with bytes 0x01..0x06 while the first frame is running → in_ready drops when fifo_count=4; bytes beyond that are accepted only after pops; all accepted bytes are transmitted in order with none lost or duplicated.
- Wrap-around: stream 10 bytes 0x30..0x39 with in_valid held high → pointers wrap twice; UART decoder on tx receives 0x30..0x39 in order.
- Simultaneous push/pop: fifo_count=2, push on the same edge IDLE pops → fifo_count stays 2, in_ready stays 1.
